mux8_1_sync: RTL and testbench

8-to-1 selector that picks one WIDTH-bit lane out of an 8-lane packed input bus, using a 3-bit select.
- Provides a combinational output for glue logic and a registered, valid-qualified copy for pipelined datapaths.
- Used wherever a single lane must be steered from an 8-source bus.

---
 rtl/mux8_1_sync.sv | 122 ++++++++++++
 tb/tb_mux8_1_sync.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux8_1_sync.sv
// mux8_1_sync: 8-to-1 lane selector with a combinational output and a registered,
// valid-qualified copy. The optional registered one-hot select output
// (sel_onehot) exists only when MUX8_1_SYNC_ONEHOT_EN is defined.
// Latency: out is 0 cycles; out_q/sel_q/out_valid/sel_changed are 1 cycle.
// Backpressure: none; a new capture is accepted on every cycle that in_valid is high.
module mux8_1_sync #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*WIDTH-1:0] in,
  input  logic [2:0]         select,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q,
  output logic               out_valid,
  output logic [2:0]         sel_q,
  output logic               sel_changed
`ifdef MUX8_1_SYNC_ONEHOT_EN
  ,
  output logic [7:0]         sel_onehot
`endif
);

  // Unpack the flat bus into an array of lanes. Lane 0 sits at the LSBs.
  logic [WIDTH-1:0] lane [8];

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign lane[k] = in[k*WIDTH +: WIDTH];
  end

  // Combinational selector. All eight codes are legal, so there is no X default.
  logic [WIDTH-1:0] mux_dat;

  // Pick lane[select]. The case is written out in full so that each code maps to one lane.
  always_comb begin
    mux_dat = lane[0];
    unique case (select)
      3'd0: mux_dat = lane[0];
      3'd1: mux_dat = lane[1];
      3'd2: mux_dat = lane[2];
      3'd3: mux_dat = lane[3];
      3'd4: mux_dat = lane[4];
      3'd5: mux_dat = lane[5];
      3'd6: mux_dat = lane[6];
      3'd7: mux_dat = lane[7];
      default: mux_dat = lane[0];
    endcase
  end

  assign out = mux_dat;

  // Register stage state.
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [2:0]       sel_idx_q, sel_idx_d;
  logic             vld_q, vld_d;
  logic             chg_q, chg_d;
  logic             capture;

  assign capture = in_valid;

  // Next-state logic. Data and select hold when nothing is captured. The valid and
  // change flags are single-cycle pulses, so they return to 0 by default.
  always_comb begin
    dat_d     = dat_q;
    sel_idx_d = sel_idx_q;
    vld_d     = 1'b0;
    chg_d     = 1'b0;
    if (capture) begin
      dat_d     = mux_dat;
      sel_idx_d = select;
      vld_d     = 1'b1;
      // Compare with the previously captured select. After reset that value is 0.
      chg_d     = (select != sel_idx_q);
    end
  end

  // State register. Reset takes priority over a capture in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q     <= '0;
      sel_idx_q <= 3'd0;
      vld_q     <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      dat_q     <= dat_d;
      sel_idx_q <= sel_idx_d;
      vld_q     <= vld_d;
      chg_q     <= chg_d;
    end
  end

  assign out_q       = dat_q;
  assign sel_q       = sel_idx_q;
  assign out_valid   = vld_q;
  assign sel_changed = chg_q;

`ifdef MUX8_1_SYNC_ONEHOT_EN
  // One-hot copy of the captured select. Its reset value matches sel_q = 0.
  logic [7:0] oh_q, oh_d;

  // One-hot next state: decode the new select on a capture, otherwise hold.
  always_comb begin
    oh_d = oh_q;
    if (capture) begin
      oh_d = 8'd1 << select;
    end
  end

  // One-hot register. It is reset and captured together with sel_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      oh_q <= 8'b0000_0001;
    end else begin
      oh_q <= oh_d;
    end
  end

  assign sel_onehot = oh_q;
`endif

endmodule

// File: tb/tb_mux8_1_sync.sv
// Testbench for mux8_1_sync, with one instance at WIDTH=1 and one at WIDTH=8.
// The bench runs directed scenarios and then randomized traffic against a reference model.
module tb_mux8_1_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=1 instance
  logic [7:0]  in1;
  logic [2:0]  sel1;
  logic        vld1, rst1;
  logic [0:0]  out1, outq1;
  logic        ovld1, chg1;
  logic [2:0]  selq1;

  // WIDTH=8 instance
  logic [63:0] in8;
  logic [2:0]  sel8;
  logic        vld8, rst8;
  logic [7:0]  out8, outq8;
  logic        ovld8, chg8;
  logic [2:0]  selq8;

`ifdef MUX8_1_SYNC_ONEHOT_EN
  logic [7:0]  oh1, oh8;
`endif

  mux8_1_sync #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .in(in1), .select(sel1), .in_valid(vld1),
    .out(out1), .out_q(outq1), .out_valid(ovld1), .sel_q(selq1), .sel_changed(chg1)
`ifdef MUX8_1_SYNC_ONEHOT_EN
    , .sel_onehot(oh1)
`endif
  );

  mux8_1_sync #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .in(in8), .select(sel8), .in_valid(vld8),
    .out(out8), .out_q(outq8), .out_valid(ovld8), .sel_q(selq8), .sel_changed(chg8)
`ifdef MUX8_1_SYNC_ONEHOT_EN
    , .sel_onehot(oh8)
`endif
  );

  // Reference model state: what each register stage should hold.
  logic [63:0] m1_q, m8_q;
  int          m1_sel, m8_sel;
  logic        m1_vld, m8_vld, m1_chg, m8_chg;
  logic [7:0]  m8_oh, m1_oh;

  function automatic logic [63:0] lane_of(input logic [63:0] bus, input int w, input int s);
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (bus >> (s * w)) & mask;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus to the WIDTH=1 instance and check both outputs.
  task automatic step1(input logic [7:0] i, input int s, input logic v, input logic r,
                       input string tag);
    logic [63:0] exp_lane;
    in1 = i; sel1 = 3'(s); vld1 = v; rst1 = r;
    #1;
    exp_lane = lane_of({56'd0, i}, 1, s);
    chk({tag, ".out"}, {63'd0, out1}, exp_lane);
    if (r) begin
      m1_q = 0; m1_sel = 0; m1_vld = 0; m1_chg = 0; m1_oh = 8'h01;
    end else if (v) begin
      m1_chg = (s != m1_sel); m1_q = exp_lane; m1_sel = s; m1_vld = 1; m1_oh = 8'(1 << s);
    end else begin
      m1_vld = 0; m1_chg = 0;
    end
    @(posedge clk); #1;
    chk({tag, ".out_q"},       {63'd0, outq1}, m1_q);
    chk({tag, ".out_valid"},   {63'd0, ovld1}, {63'd0, m1_vld});
    chk({tag, ".sel_q"},       {61'd0, selq1}, 64'(m1_sel));
    chk({tag, ".sel_changed"}, {63'd0, chg1},  {63'd0, m1_chg});
`ifdef MUX8_1_SYNC_ONEHOT_EN
    chk({tag, ".sel_onehot"},  {56'd0, oh1},   {56'd0, m1_oh});
`endif
  endtask

  // Apply one cycle of stimulus to the WIDTH=8 instance and check both outputs.
  task automatic step8(input logic [63:0] i, input int s, input logic v, input logic r,
                       input string tag);
    logic [63:0] exp_lane;
    in8 = i; sel8 = 3'(s); vld8 = v; rst8 = r;
    #1;
    exp_lane = lane_of(i, 8, s);
    chk({tag, ".out"}, {56'd0, out8}, exp_lane);
    if (r) begin
      m8_q = 0; m8_sel = 0; m8_vld = 0; m8_chg = 0; m8_oh = 8'h01;
    end else if (v) begin
      m8_chg = (s != m8_sel); m8_q = exp_lane; m8_sel = s; m8_vld = 1; m8_oh = 8'(1 << s);
    end else begin
      m8_vld = 0; m8_chg = 0;
    end
    @(posedge clk); #1;
    chk({tag, ".out_q"},       {56'd0, outq8}, m8_q);
    chk({tag, ".out_valid"},   {63'd0, ovld8}, {63'd0, m8_vld});
    chk({tag, ".sel_q"},       {61'd0, selq8}, 64'(m8_sel));
    chk({tag, ".sel_changed"}, {63'd0, chg8},  {63'd0, m8_chg});
`ifdef MUX8_1_SYNC_ONEHOT_EN
    chk({tag, ".sel_onehot"},  {56'd0, oh8},   {56'd0, m8_oh});
`endif
  endtask

  initial begin
    logic [63:0] rbus;
    m1_q = 0; m8_q = 0; m1_sel = 0; m8_sel = 0;
    m1_vld = 0; m8_vld = 0; m1_chg = 0; m8_chg = 0; m1_oh = 8'h01; m8_oh = 8'h01;
    in1 = 8'd0; sel1 = 3'd0; vld1 = 1'b0; rst1 = 1'b1;
    in8 = 64'd0; sel8 = 3'd0; vld8 = 1'b0; rst8 = 1'b1;
    @(posedge clk); #1;

    // Reset state, with a pending capture being ignored.
    step1(8'h00, 0, 1'b1, 1'b1, "rst1");
    step8(64'h0, 0, 1'b1, 1'b1, "rst8");

    // Plan 1: the first capture after reset, with select=2, must raise sel_changed.
    step1(8'b0000_0001, 2, 1'b1, 1'b0, "p1");

    // Plan 2: run back-to-back captures.
    step1(8'b0000_0010, 1, 1'b1, 1'b0, "p2a");
    step1(8'b0000_0011, 0, 1'b1, 1'b0, "p2b");
    step1(8'b0000_0100, 2, 1'b1, 1'b0, "p2c");

    // Plan 3: exercise lane 3 and lane 7.
    step1(8'b0000_0110, 3, 1'b1, 1'b0, "p3a");
    step1(8'b1000_0000, 7, 1'b1, 1'b0, "p3b");

    // Plan 4: repeat select=2, then hold with in_valid low while the bus changes.
    step1(8'b0000_0100, 2, 1'b1, 1'b0, "p4a");
    step1(8'b0000_0000, 2, 1'b1, 1'b0, "p4b");
    step1(8'b1111_1111, 5, 1'b0, 1'b0, "p4c");
    step1(8'b0000_0000, 5, 1'b0, 1'b0, "p4d");

    // Plan 5: reset mid-stream while in_valid is high and all lanes are 1.
    step1(8'hFF, 6, 1'b1, 1'b0, "p5a");
    step1(8'hFF, 6, 1'b1, 1'b1, "p5b");
    step1(8'h01, 0, 1'b1, 1'b0, "p5c");

    // Plan 6: sweep every select code on the WIDTH=8 instance.
    for (int s = 0; s < 8; s++) begin
      step8(64'h0706050403020100, s, 1'b1, 1'b0, $sformatf("p6_s%0d", s));
    end
    step8(64'hFFEEDDCCBBAA9988, 7, 1'b1, 1'b0, "p6_same");
    step8(64'h1122334455667788, 1, 1'b0, 1'b0, "p6_hold");

    // Randomized traffic, with an occasional reset.
    for (int n = 0; n < 300; n++) begin
      rbus = {$urandom, $urandom};
      step1(rbus[7:0], int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), "rnd1");
      rbus = {$urandom, $urandom};
      step8(rbus, int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), "rnd8");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
